// File: rtl/exposure_sequencer_if.sv
// Command/status bundle between the host command FSM, the exposure sequencer,
// the shutter PWM and the CCD readout block.
`timescale 1ns/1ps

interface exposure_sequencer_if #(
    parameter int EXP_W = 24
);
    logic             start;
    logic             abort;
    logic             dark;
    logic [EXP_W-1:0] exp_ms;
    logic             ccd_busy;

    logic             shutter_open;
    logic             ccd_toggle;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             error;
    logic [2:0]       state_out;

    // Environment side: command FSM plus the CCD readout busy flag.
    modport master (
        output start, abort, dark, exp_ms, ccd_busy,
        input  shutter_open, ccd_toggle, busy, done, aborted, error, state_out
    );

    modport slave (
        input  start, abort, dark, exp_ms, ccd_busy,
        output shutter_open, ccd_toggle, busy, done, aborted, error, state_out
    );
endinterface

// File: rtl/exposure_sequencer.sv
// Runs one CCD exposure: shutter open/settle, exposure timing, close/settle, readout trigger.
// Optional readout-start watchdog enabled by defining EXPSEQ_TIMEOUT_EN.
`timescale 1ns/1ps

module exposure_sequencer #(
    parameter int TICK_DIV       = 100000,
    parameter int SETTLE_MS      = 300,
    parameter int EXP_W          = 24,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    exposure_sequencer_if.slave  bus
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_OPEN_SETTLE  = 3'd1;
    localparam logic [2:0] S_EXPOSE       = 3'd2;
    localparam logic [2:0] S_CLOSE_SETTLE = 3'd3;
    localparam logic [2:0] S_TRIGGER      = 3'd4;
    localparam logic [2:0] S_WAIT_DONE    = 3'd5;
    localparam logic [2:0] S_DONE         = 3'd6;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [EXP_W-1:0]  SETTLE_LEN = EXP_W'(SETTLE_MS);

`ifdef EXPSEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    // Without the watchdog TRIGGER waits on ccd_busy forever and error stays 0.
    localparam bit TO_EN = 1'b0;
`endif

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic [EXP_W-1:0]  ms_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [EXP_W-1:0]  exp_q;
    logic              dark_q;
    logic              abort_q;
    logic              shutter_q;
    logic              aborted_q;
    logic              error_q;

    logic              accept;
    logic              timed_state;
    logic [EXP_W-1:0]  wait_len;
    logic              wait_over;
    logic              timed_out;
    logic              shutter_nxt;

    assign accept      = (state == S_IDLE) && bus.start && !bus.abort;
    assign timed_state = (state == S_OPEN_SETTLE) || (state == S_EXPOSE) ||
                         (state == S_CLOSE_SETTLE);
    assign wait_len    = (state == S_EXPOSE) ? exp_q : SETTLE_LEN;

    // A zero-length wait still spends one cycle in the state; ms_cnt never
    // exceeds wait_len-1, so the maximum exposure cannot wrap the counter.
    assign wait_over   = (wait_len == '0) ||
                         ((tick_cnt == TICK_LAST) && (ms_cnt == wait_len - EXP_W'(1)));

    assign timed_out   = TO_EN && (state == S_TRIGGER) && (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = bus.dark ? S_EXPOSE : S_OPEN_SETTLE;
                end
            end
            S_OPEN_SETTLE: begin
                if (bus.abort) begin
                    state_nxt = S_CLOSE_SETTLE;
                end else if (wait_over) begin
                    state_nxt = S_EXPOSE;
                end
            end
            S_EXPOSE: begin
                if (bus.abort) begin
                    state_nxt = dark_q ? S_IDLE : S_CLOSE_SETTLE;
                end else if (wait_over) begin
                    state_nxt = dark_q ? S_TRIGGER : S_CLOSE_SETTLE;
                end
            end
            S_CLOSE_SETTLE: begin
                if (wait_over) begin
                    state_nxt = (abort_q || bus.abort) ? S_IDLE : S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                if (bus.ccd_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (timed_out) begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.ccd_busy) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shutter is open only while heading for OPEN_SETTLE, or staying in a light
    // EXPOSE; a dark start goes IDLE->EXPOSE and is excluded by the state check.
    assign shutter_nxt = (state_nxt == S_OPEN_SETTLE) ||
                         ((state_nxt == S_EXPOSE) && (state != S_IDLE) && !dark_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            ms_cnt    <= '0;
            to_cnt    <= '0;
            dark_q    <= 1'b0;
            abort_q   <= 1'b0;
            shutter_q <= 1'b0;
            aborted_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shutter_q <= shutter_nxt;
            // Only an abort returns to IDLE from anywhere other than DONE.
            aborted_q <= (state_nxt == S_IDLE) && (state != S_IDLE) && (state != S_DONE);

            if ((state_nxt != state) || !timed_state) begin
                tick_cnt <= '0;
                ms_cnt   <= '0;
            end else if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                ms_cnt   <= ms_cnt + EXP_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end

            if (state == S_TRIGGER) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            if (accept) begin
                dark_q  <= bus.dark;
                abort_q <= 1'b0;
                error_q <= 1'b0;
            end else begin
                if (bus.abort && timed_state) begin
                    abort_q <= 1'b1;
                end
                if (timed_out && !bus.ccd_busy) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    // Exposure length is pure data: only meaningful after an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            exp_q <= bus.exp_ms;
        end
    end

    assign bus.shutter_open = shutter_q;
    assign bus.ccd_toggle   = (state == S_TRIGGER);
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE);
    assign bus.aborted      = aborted_q;
    assign bus.error        = TO_EN ? error_q : 1'b0;
    assign bus.state_out    = state;

endmodule
